// File: rtl/manchester_tx_pkg.sv
// Shared types for the Manchester transmitter: FSM state and half-bit phase.
// Optional feature macro: MANCHESTER_TX_PREAMBLE_EN (preamble word per frame).
package manchester_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        EOF  = 2'd3
    } state_t;

    typedef enum logic {
        HALF_FIRST  = 1'b0,
        HALF_SECOND = 1'b1
    } phase_t;

    // Clocks per half-bit period.
    function automatic int calc_div(input int clkfreq, input int baud);
        return clkfreq / (2 * baud);
    endfunction

endpackage

// File: rtl/manchester_tx_p_halfbit_enb.sv
// Half-bit tick generator. enb is high for exactly one cycle every DIV cycles,
// namely the last cycle of each half-bit. clr restarts the count so that the
// first cycle after clr drops is cycle 0 of a fresh half-bit.
module halfbit_enb #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic enb
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV counter; enb is registered one cycle ahead so it
    // lines up with the cycle whose count is LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            enb <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            enb <= 1'b0;
        end else begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
            enb <= (cnt == PRE_LAST);
        end
    end

endmodule

// File: rtl/manchester_tx_p.sv
// Manchester transmitter with a one-word holding register.
// Each bit is sent LSB first as (~bit, bit), each half DIV clocks long. Words
// queued in the holding register before the current word ends are chained
// without a gap; a frame ends with EOF_BITS idle-high bit periods.
// Optional feature macro: MANCHESTER_TX_PREAMBLE_EN sends one alternating
// 1,0,... preamble word ahead of the first data word of every frame.
//
// Handshake: a word is accepted on any cycle where send=1 and rdy=1. rdy is
// high while the holding register is empty; send is ignored while rdy=0.
module manchester_tx_p
    import manchester_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CLKFREQ  = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int EOF_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              send,
    output logic              txd,
    output logic              txen,
    output logic              rdy,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int DIV        = calc_div(CLKFREQ, BAUD);
    localparam int BW         = $clog2(DATA_W);
    localparam int EOF_HALVES = 2 * EOF_BITS;

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [3:0]    EOF_LAST = 4'(EOF_HALVES - 1);

    if (DIV < 2) begin : g_bad_div
        $error("manchester_tx_p: CLKFREQ/(2*BAUD) must be at least 2");
    end
    if (DATA_W < 4 || DATA_W > 32) begin : g_bad_width
        $error("manchester_tx_p: DATA_W must be 4..32");
    end
    if (EOF_BITS < 1 || EOF_BITS > 7) begin : g_bad_eof
        $error("manchester_tx_p: EOF_BITS must be 1..7");
    end

    state_t            state;
    phase_t            phase;
    logic [BW-1:0]     bit_cnt;
    logic [3:0]        eof_cnt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shreg;
    logic              load_pend;
    logic              enb;
    logic              bit_now;
    logic              next_first;
    logic              start_bit0;

    assign state_dbg = state;

    // Divider is held cleared while idle so a new frame starts on a clean half.
    halfbit_enb #(
        .DIV (DIV)
    ) u_halfbit_enb (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .enb (enb)
    );

    // Current bit value and the first-half level of the following bit. The
    // preamble bit k is 1 for even k, so both follow directly from bit_cnt.
    always_comb begin
        bit_now    = shreg[0];
        next_first = ~shreg[1];
        start_bit0 = rdy ? data[0] : hold[0];
        if (state == PRE) begin
            bit_now    = ~bit_cnt[0];
            next_first = ~bit_cnt[0];
        end
    end

    // Frame FSM, holding register and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase     <= HALF_FIRST;
            bit_cnt   <= '0;
            eof_cnt   <= '0;
            hold      <= '0;
            shreg     <= '0;
            load_pend <= 1'b0;
            txd       <= 1'b1;
            txen      <= 1'b0;
            rdy       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (send && rdy) begin
                hold <= data;
                rdy  <= 1'b0;
            end
            // Word start: the queued word moves into the shifter one cycle
            // after its first half-bit begins; the holding register frees up.
            if (load_pend) begin
                shreg     <= hold;
                rdy       <= 1'b1;
                load_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rdy || send) begin
                        txen    <= 1'b1;
                        busy    <= 1'b1;
                        phase   <= HALF_FIRST;
                        bit_cnt <= '0;
`ifdef MANCHESTER_TX_PREAMBLE_EN
                        state   <= PRE;
                        txd     <= 1'b0;
`else
                        state     <= DATA;
                        txd       <= ~start_bit0;
                        load_pend <= 1'b1;
`endif
                    end
                end

                PRE, DATA: begin
                    if (enb) begin
                        if (phase == HALF_FIRST) begin
                            phase <= HALF_SECOND;
                            txd   <= bit_now;
                        end else begin
                            phase <= HALF_FIRST;
                            if (bit_cnt != LAST_BIT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                txd     <= next_first;
                                shreg   <= shreg >> 1;
                            end else begin
                                bit_cnt <= '0;
                                if (!rdy) begin
                                    // Next word already queued: chain with no gap.
                                    state     <= DATA;
                                    txd       <= ~hold[0];
                                    load_pend <= 1'b1;
                                end else begin
                                    state   <= EOF;
                                    txd     <= 1'b1;
                                    eof_cnt <= '0;
                                end
                            end
                        end
                    end
                end

                EOF: begin
                    if (enb) begin
                        if (eof_cnt == EOF_LAST) begin
                            state <= IDLE;
                            txen  <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            eof_cnt <= eof_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_tx_p.sv
// Bench for manchester_tx_p with CLKFREQ=100, BAUD=10 (DIV=5), DATA_W=8,
// EOF_BITS=2. A line monitor decodes txd into words and compares them with
// the words accepted by the driver, plus frame-level timing checks.
module tb_manchester_tx_p;

    localparam int DIV      = 5;
    localparam int PER      = 2 * DIV;
    localparam int EOF_CYC  = 2 * 2 * DIV;
`ifdef MANCHESTER_TX_PREAMBLE_EN
    localparam int  EOF_WAIT = 165;
    localparam logic RDY_C2  = 1'b0;
`else
    localparam int  EOF_WAIT = 85;
    localparam logic RDY_C2  = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd, txen, rdy, busy;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    manchester_tx_p #(
        .DATA_W   (8),
        .CLKFREQ  (100),
        .BAUD     (10),
        .EOF_BITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .send      (send),
        .txd       (txd),
        .txen      (txen),
        .rdy       (rdy),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Presents w with send=1 and holds it until rdy allows the accept.
    task automatic put_word(input logic [7:0] w);
        int guard = 0;
        @(negedge clk);
        data = w;
        send = 1'b1;
        while (!rdy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy) begin
            check("accept_timeout", rdy, 1);
        end else begin
            accept_cyc = cyc;
            @(posedge clk);
            exp_q.push_back(w);
            #1;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((busy || txen || !rdy) && g < 5000);
        if (g >= 5000) check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic            in_frame = 1'b0;
    logic            in_eof = 1'b0;
    logic            lost = 1'b0;
    logic            eof_bad = 1'b0;
    logic [PER-1:0]  per;
    logic [7:0]      word_acc;
    int              pos = 0;
    int              nbits = 0;
    int              eof_len = 0;
    int              words_in_frame = 0;
    int              frames_done = 0;
    int              last_frame_words = 0;
    int              frame_start_cyc = 0;

    task automatic word_done();
`ifdef MANCHESTER_TX_PREAMBLE_EN
        if (nbits == 8) begin
            check("preamble_word", word_acc, 8'h55);
            return;
        end
`endif
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %02h, required no word on line", word_acc);
        end else begin
            check("serial_word", word_acc, exp_q.pop_front());
        end
        words_in_frame++;
    endtask

    task automatic decode_period();
        logic [DIV-1:0] first, second;
        first  = per[DIV-1:0];
        second = per[PER-1:DIV];
        if (first == '1 && second == '1) begin
            in_eof  = 1'b1;
            eof_len = PER;
            eof_bad = 1'b0;
            check("word_boundary_at_eof", nbits % 8, 0);
        end else if ((first == '0 && second == '1) || (first == '1 && second == '0)) begin
            word_acc[nbits % 8] = second[0];
            nbits++;
            if (nbits % 8 == 0) word_done();
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL half_shape: got %b, required two constant complementary halves", per);
            lost = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
                in_eof   = 1'b0;
                lost     = 1'b0;
            end else if (!in_frame) begin
                if (txen) begin
                    in_frame        = 1'b1;
                    in_eof          = 1'b0;
                    lost            = 1'b0;
                    nbits           = 0;
                    words_in_frame  = 0;
                    frame_start_cyc = cyc;
                    per[0]          = txd;
                    pos             = 1;
                end
            end else if (lost) begin
                if (!txen) in_frame = 1'b0;
            end else if (in_eof) begin
                if (txen) begin
                    eof_len++;
                    if (txd !== 1'b1) eof_bad = 1'b1;
                end else begin
                    check("eof_length", eof_len, EOF_CYC);
                    check("eof_txd_high", eof_bad, 0);
                    in_frame         = 1'b0;
                    in_eof           = 1'b0;
                    frames_done++;
                    last_frame_words = words_in_frame;
                end
            end else if (!txen) begin
                check("txen_during_data", txen, 1);
                in_frame = 1'b0;
            end else begin
                per[pos] = txd;
                pos++;
                if (pos == PER) begin
                    pos = 0;
                    decode_period();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        int mode;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_outputs", {txd, txen, rdy, busy}, 4'b1010);
        end

        // Single word 0xA5: latency, rdy timing, exact waveform via monitor.
        put_word(8'hA5);
        send = 1'b0;
        check("rdy_after_accept", rdy, 0);
        @(negedge clk);
        check("cycle1_busy_txen_txd", {busy, txen, txd}, 3'b110);
        @(negedge clk);
        check("rdy_cycle2", rdy, RDY_C2);
        wait_idle();
        check("frame_start_latency", frame_start_cyc - accept_cyc, 1);
        check("single_frame_words", last_frame_words, 1);

        // Back-to-back words chain into one frame.
        put_word(8'h0F);
        put_word(8'hF0);
        send = 1'b0;
        wait_idle();
        check("b2b_frame_words", last_frame_words, 2);

        // Back-pressure: send held high across three words.
        put_word(8'h11);
        put_word(8'h22);
        put_word(8'h33);
        send = 1'b0;
        wait_idle();
        check("bp_frame_words", last_frame_words, 3);

        // Accept during EOF starts a separate frame.
        f0 = frames_done;
        put_word(8'hC3);
        send = 1'b0;
        repeat (EOF_WAIT) @(negedge clk);
        check("in_eof_txd_txen", {txd, txen}, 2'b11);
        put_word(8'h96);
        send = 1'b0;
        wait_idle();
        check("eof_accept_frames", frames_done - f0, 2);
        check("eof_accept_words", last_frame_words, 1);

        // Reset mid-frame aborts immediately.
        put_word(8'h3C);
        send = 1'b0;
        repeat (39) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {txd, txen, rdy, busy}, 4'b1010);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        put_word(8'h01);
        send = 1'b0;
        wait_idle();
        check("post_reset_frame_words", last_frame_words, 1);

        // Randomized words with random spacing.
        for (int i = 0; i < 20; i++) begin
            put_word(8'($urandom_range(0, 255)));
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                send = 1'b0;
                wait_idle();
            end else if (mode == 1) begin
                send = 1'b0;
                repeat ($urandom_range(0, 200)) @(negedge clk);
            end
        end
        send = 1'b0;
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
